// File: rtl/vx_sfu_pe_router_if.sv
// Bundle of every request, response and status signal of vx_sfu_pe_router.
// The master modport is the environment side (SFU blocks plus PEs), and the
// slave modport is the router itself.
// SFU_ROUTER_PERF_EN adds the perf_stall_cycles status vector.
interface vx_sfu_pe_router_if #(
  parameter int NUM_BLOCKS = 1,
  parameter int PE_COUNT   = 5,
  parameter int DATA_W     = 64,
  parameter int RSP_W      = 64
) ();
  localparam int PE_SEL_BITS = $clog2(PE_COUNT);

  // block -> router request channels
  logic [NUM_BLOCKS-1:0]             req_valid;
  logic [NUM_BLOCKS*DATA_W-1:0]      req_data;
  logic [NUM_BLOCKS*PE_SEL_BITS-1:0] req_pe_sel;
  logic [NUM_BLOCKS-1:0]             req_ready;
  // router -> PE requests
  logic [PE_COUNT-1:0]               pe_req_valid;
  logic [PE_COUNT*DATA_W-1:0]        pe_req_data;
  logic [PE_COUNT-1:0]               pe_req_ready;
  // PE -> router responses
  logic [PE_COUNT-1:0]               pe_rsp_valid;
  logic [PE_COUNT*RSP_W-1:0]         pe_rsp_data;
  logic [PE_COUNT-1:0]               pe_rsp_ready;
  // router -> block commit channels
  logic [NUM_BLOCKS-1:0]             rsp_valid;
  logic [NUM_BLOCKS*RSP_W-1:0]       rsp_data;
  logic [NUM_BLOCKS-1:0]             rsp_ready;
  // status
  logic                              busy;
  logic                              err;
`ifdef SFU_ROUTER_PERF_EN
  logic [PE_COUNT*32-1:0]            perf_stall_cycles;

  modport master (
    output req_valid, req_data, req_pe_sel, pe_req_ready,
           pe_rsp_valid, pe_rsp_data, rsp_ready,
    input  req_ready, pe_req_valid, pe_req_data, pe_rsp_ready,
           rsp_valid, rsp_data, busy, err, perf_stall_cycles
  );
  modport slave (
    input  req_valid, req_data, req_pe_sel, pe_req_ready,
           pe_rsp_valid, pe_rsp_data, rsp_ready,
    output req_ready, pe_req_valid, pe_req_data, pe_rsp_ready,
           rsp_valid, rsp_data, busy, err, perf_stall_cycles
  );
`else
  modport master (
    output req_valid, req_data, req_pe_sel, pe_req_ready,
           pe_rsp_valid, pe_rsp_data, rsp_ready,
    input  req_ready, pe_req_valid, pe_req_data, pe_rsp_ready,
           rsp_valid, rsp_data, busy, err
  );
  modport slave (
    input  req_valid, req_data, req_pe_sel, pe_req_ready,
           pe_rsp_valid, pe_rsp_data, rsp_ready,
    output req_ready, pe_req_valid, pe_req_data, pe_rsp_ready,
           rsp_valid, rsp_data, busy, err
  );
`endif
endinterface

// File: rtl/vx_sfu_pe_router.sv
// Request/commit router between NUM_BLOCKS SFU dispatch blocks and PE_COUNT
// processing elements. Requests are arbitrated round-robin per PE. A per-PE
// tag FIFO remembers the issuing block, so in-order PE responses are steered
// back to that block through one registered output stage per block.
// Optional feature: define SFU_ROUTER_PERF_EN for per-PE stall counters.
module vx_sfu_pe_router #(
  parameter int NUM_BLOCKS   = 1,
  parameter int PE_COUNT     = 5,
  parameter int DATA_W       = 64,
  parameter int RSP_W        = 64,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_sfu_pe_router_if.slave     bus
);
  localparam int PE_SEL_BITS = $clog2(PE_COUNT);
  localparam int BID_W       = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int PTR_W       = $clog2(MAX_INFLIGHT);
  localparam int CNT_W       = PTR_W + 1;

  // tag FIFOs, one per PE
  logic [BID_W-1:0]       r_tag_mem [PE_COUNT][MAX_INFLIGHT];
  logic [PTR_W-1:0]       r_wr_ptr  [PE_COUNT];
  logic [PTR_W-1:0]       r_rd_ptr  [PE_COUNT];
  logic [CNT_W-1:0]       r_cnt     [PE_COUNT];
  // round-robin pointers hold the last grant
  logic [BID_W-1:0]       r_req_ptr [PE_COUNT];
  logic [PE_SEL_BITS-1:0] r_rsp_ptr [NUM_BLOCKS];
  // per-block output registers
  logic [NUM_BLOCKS-1:0]  r_out_valid;
  logic [RSP_W-1:0]       r_out_data [NUM_BLOCKS];
  logic                   r_err;

  logic [PE_SEL_BITS-1:0]     w_sel      [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0]      w_bad_sel;
  logic [PE_COUNT-1:0]        w_cand_any;
  logic [BID_W-1:0]           w_req_gnt  [PE_COUNT];
  logic [PE_COUNT-1:0]        w_pe_req_valid;
  logic [PE_COUNT*DATA_W-1:0] w_pe_req_data;
  logic [PE_COUNT-1:0]        w_push;
  logic [NUM_BLOCKS-1:0]      w_req_ready;
  logic [BID_W-1:0]           w_head     [PE_COUNT];
  logic [PE_COUNT-1:0]        w_nonempty;
  logic [NUM_BLOCKS-1:0]      w_rsp_any;
  logic [PE_SEL_BITS-1:0]     w_rsp_gnt  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0]      w_load;
  logic [PE_COUNT-1:0]        w_pop;
  logic [PE_COUNT-1:0]        w_rsp_drop;
  logic                       w_busy;

  // Request path: round-robin pick per PE, credit gate, fire and drop decode.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    idx            = 0;
    w_bad_sel      = '0;
    w_cand_any     = '0;
    w_pe_req_valid = '0;
    w_pe_req_data  = '0;
    w_push         = '0;
    w_req_ready    = '0;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      w_sel[b]     = bus.req_pe_sel[b*PE_SEL_BITS +: PE_SEL_BITS];
      w_bad_sel[b] = bus.req_valid[b] && (int'(w_sel[b]) >= PE_COUNT);
    end
    for (int p = 0; p < PE_COUNT; p++) begin
      w_req_gnt[p] = '0;
      for (int i = 1; i <= NUM_BLOCKS; i++) begin
        idx = (int'(r_req_ptr[p]) + i) % NUM_BLOCKS;
        if (!w_cand_any[p] && bus.req_valid[idx] && (w_sel[idx] == PE_SEL_BITS'(p))) begin
          w_cand_any[p] = 1'b1;
          w_req_gnt[p]  = BID_W'(idx);
        end
      end
      // credit check looks at the registered count only
      w_pe_req_valid[p] = w_cand_any[p] && (r_cnt[p] < CNT_W'(MAX_INFLIGHT));
      w_pe_req_data[p*DATA_W +: DATA_W] = bus.req_data[int'(w_req_gnt[p])*DATA_W +: DATA_W];
      w_push[p] = w_pe_req_valid[p] && bus.pe_req_ready[p];
    end
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      w_req_ready[b] = w_bad_sel[b];
      for (int p = 0; p < PE_COUNT; p++) begin
        if (w_push[p] && (w_req_gnt[p] == BID_W'(b))) w_req_ready[b] = 1'b1;
      end
    end
  end

  // Response path: per-block round-robin over PEs whose head tag names it.
  always_comb begin
    int idx;
    idx        = 0;
    w_rsp_any  = '0;
    w_load     = '0;
    w_pop      = '0;
    for (int p = 0; p < PE_COUNT; p++) begin
      w_head[p]     = r_tag_mem[p][r_rd_ptr[p]];
      w_nonempty[p] = (r_cnt[p] != '0);
    end
    w_rsp_drop = bus.pe_rsp_valid & ~w_nonempty;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      w_rsp_gnt[b] = '0;
      for (int i = 1; i <= PE_COUNT; i++) begin
        idx = (int'(r_rsp_ptr[b]) + i) % PE_COUNT;
        if (!w_rsp_any[b] && bus.pe_rsp_valid[idx] && w_nonempty[idx] &&
            (w_head[idx] == BID_W'(b))) begin
          w_rsp_any[b] = 1'b1;
          w_rsp_gnt[b] = PE_SEL_BITS'(idx);
        end
      end
      w_load[b] = !r_out_valid[b] || bus.rsp_ready[b];
      for (int p = 0; p < PE_COUNT; p++) begin
        if (w_rsp_any[b] && w_load[b] && (w_rsp_gnt[b] == PE_SEL_BITS'(p))) w_pop[p] = 1'b1;
      end
    end
    w_busy = |r_out_valid;
    for (int p = 0; p < PE_COUNT; p++) w_busy = w_busy || w_nonempty[p];
  end

  // Tag storage written on every request fire.
  // NOTE: the tag array is left out of reset; r_cnt alone decides which entries are valid.
  always_ff @(posedge clk) begin
    for (int p = 0; p < PE_COUNT; p++) begin
      if (w_push[p]) r_tag_mem[p][r_wr_ptr[p]] <= w_req_gnt[p];
    end
  end

  // FIFO pointers/counts, RR pointers, output registers and sticky error.
  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PE_COUNT; p++) begin
        r_wr_ptr[p]  <= '0;
        r_rd_ptr[p]  <= '0;
        r_cnt[p]     <= '0;
        r_req_ptr[p] <= BID_W'(NUM_BLOCKS - 1);
      end
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        r_rsp_ptr[b]  <= PE_SEL_BITS'(PE_COUNT - 1);
        r_out_data[b] <= '0;
      end
      r_out_valid <= '0;
      r_err       <= 1'b0;
    end else begin
      for (int p = 0; p < PE_COUNT; p++) begin
        if (w_push[p]) begin
          r_wr_ptr[p]  <= r_wr_ptr[p] + 1'b1;
          r_req_ptr[p] <= w_req_gnt[p];
        end
        if (w_pop[p]) r_rd_ptr[p] <= r_rd_ptr[p] + 1'b1;
        if (w_push[p] && !w_pop[p])      r_cnt[p] <= r_cnt[p] + 1'b1;
        else if (!w_push[p] && w_pop[p]) r_cnt[p] <= r_cnt[p] - 1'b1;
      end
      for (int b = 0; b < NUM_BLOCKS; b++) begin
        if (w_load[b]) begin
          r_out_valid[b] <= w_rsp_any[b];
          if (w_rsp_any[b]) begin
            r_out_data[b] <= bus.pe_rsp_data[int'(w_rsp_gnt[b])*RSP_W +: RSP_W];
            r_rsp_ptr[b]  <= w_rsp_gnt[b];
          end
        end
      end
      if ((|w_bad_sel) || (|w_rsp_drop)) r_err <= 1'b1;
    end
  end

`ifdef SFU_ROUTER_PERF_EN
  logic [31:0] r_stall [PE_COUNT];

  // Wrapping per-PE count of cycles with a candidate but no fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < PE_COUNT; p++) r_stall[p] <= '0;
    end else begin
      for (int p = 0; p < PE_COUNT; p++) begin
        if (w_cand_any[p] && !w_push[p]) r_stall[p] <= r_stall[p] + 32'd1;
      end
    end
  end

  for (genvar gp = 0; gp < PE_COUNT; gp++) begin : g_perf
    assign bus.perf_stall_cycles[gp*32 +: 32] = r_stall[gp];
  end
`endif

  for (genvar gb = 0; gb < NUM_BLOCKS; gb++) begin : g_rsp
    assign bus.rsp_data[gb*RSP_W +: RSP_W] = r_out_data[gb];
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.pe_req_valid = w_pe_req_valid;
  assign bus.pe_req_data  = w_pe_req_data;
  assign bus.pe_rsp_ready = w_pop | w_rsp_drop;
  assign bus.rsp_valid    = r_out_valid;
  assign bus.busy         = w_busy;
  assign bus.err          = r_err;
endmodule
